// File: rtl/key_sched_pkg.sv
// Shared definitions for the round-key generator: widths, round-constant
// seed and reduction polynomial, and the controller state encoding.
package key_sched_pkg;

    localparam int KEY_W = 32;
    localparam int RK_W  = 8;
    localparam int IDX_W = 4;

    localparam logic [RK_W-1:0] RC_INIT = 8'h01;
    localparam logic [RK_W-1:0] RC_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gf_xtime.sv
// GF(2^8) doubling: shift left one bit and reduce by the AES polynomial
// when the bit shifted out was set.
module gf_xtime
    import key_sched_pkg::*;
(
    input  logic [RK_W-1:0] x,
    output logic [RK_W-1:0] y
);

    // Pure combinational doubling, reduction applied on carry-out.
    always_comb begin
        y = {x[RK_W-2:0], 1'b0} ^ (x[RK_W-1] ? RC_POLY : '0);
    end

endmodule

// File: rtl/key_schedule.sv
// Round-key generator: loads a 32-bit master key and presents one 8-bit
// round key per handshake, each being the top key byte XOR a round constant.
// The key rotates left by a byte and the constant doubles in GF(2^8) on
// every accepted round key.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for key_load; outputs quiet
// GEN     | presenting round_key for round_idx, advancing on handshake
// DONE    | one-cycle completion pulse, loads ignored
module key_schedule
    import key_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  round_key,
    output logic             rk_valid,
    output logic [IDX_W-1:0] round_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

    state_e           state_q,     state_d;
    logic [KEY_W-1:0] key_reg_q,   key_reg_d;
    logic [RK_W-1:0]  rc_q,        rc_d;
    logic [IDX_W-1:0] round_idx_q, round_idx_d;
    logic [RK_W-1:0]  rc_next;

    gf_xtime u_gf_xtime (
        .x (rc_q),
        .y (rc_next)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_reg_q   <= '0;
            rc_q        <= RC_INIT;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            key_reg_q   <= key_reg_d;
            rc_q        <= rc_d;
            round_idx_q <= round_idx_d;
        end
    end

    // Next-state: load in IDLE, rotate/double on each handshake in GEN,
    // hold the index on the final round so it never leaves 0..NUM_ROUNDS-1.
    always_comb begin
        state_d     = state_q;
        key_reg_d   = key_reg_q;
        rc_d        = rc_q;
        round_idx_d = round_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    state_d     = ST_GEN;
                    key_reg_d   = key_in;
                    rc_d        = RC_INIT;
                    round_idx_d = '0;
                end
            end
            ST_GEN: begin
                if (rk_ready) begin
                    key_reg_d = {key_reg_q[KEY_W-RK_W-1:0], key_reg_q[KEY_W-1:KEY_W-RK_W]};
                    rc_d      = rc_next;
                    if (round_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        round_idx_d = round_idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        rk_valid  = (state_q == ST_GEN);
        round_key = rk_valid ? (key_reg_q[KEY_W-1:KEY_W-RK_W] ^ rc_q) : '0;
        round_idx = round_idx_q;
        busy      = (state_q == ST_GEN) || (state_q == ST_DONE);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: two instances (4 and 10 rounds) share stimulus;
// a per-instance reference model is compared every cycle, and directed
// literal checks pin the expected round-key sequences.
module tb_key_schedule;

    logic        clk;
    logic        rst;
    logic [31:0] key_in;
    logic        key_load;
    logic        rk_ready;

    logic [7:0] rk4, rk10;
    logic       v4, v10, b4, b10, d4, d10;
    logic [3:0] i4, i10;

    int checks = 0;
    int errors = 0;

    key_schedule #(.NUM_ROUNDS(4)) u4 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .rk_ready(rk_ready), .round_key(rk4), .rk_valid(v4),
        .round_idx(i4), .busy(b4), .done(d4)
    );

    key_schedule #(.NUM_ROUNDS(10)) u10 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .rk_ready(rk_ready), .round_key(rk10), .rk_valid(v10),
        .round_idx(i10), .busy(b10), .done(d10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 generating, 2 done.
    const logic [7:0] rctab [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                     8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A};
    int          nr    [2] = '{4, 10};
    int          m_st  [2];
    logic [31:0] m_key [2];
    int          m_idx [2];

    // Round key i is master-key byte (i mod 4, MSB first) XOR the i-th constant.
    function automatic logic [7:0] exp_rk(input int i);
        logic [31:0] sh;
        if (m_st[i] != 1) return 8'h00;
        sh = m_key[i] >> (8 * (3 - (m_idx[i] % 4)));
        return sh[7:0] ^ rctab[m_idx[i]];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_st[i]  <= 0;
                m_key[i] <= '0;
                m_idx[i] <= 0;
            end else begin
                case (m_st[i])
                    0: if (key_load) begin
                        m_st[i]  <= 1;
                        m_key[i] <= key_in;
                        m_idx[i] <= 0;
                    end
                    1: if (rk_ready) begin
                        if (m_idx[i] == nr[i] - 1) m_st[i] <= 2;
                        else m_idx[i] <= m_idx[i] + 1;
                    end
                    default: m_st[i] <= 0;
                endcase
            end
        end
    end

    task automatic cmp(input int i, input logic [7:0] rk, input logic v,
                       input logic [3:0] idx, input logic b, input logic d);
        chk($sformatf("model_rk%0d", nr[i]),    {24'h0, rk},  {24'h0, exp_rk(i)});
        chk($sformatf("model_valid%0d", nr[i]), {31'h0, v},   {31'h0, m_st[i] == 1});
        chk($sformatf("model_idx%0d", nr[i]),   {28'h0, idx}, 32'(m_idx[i]));
        chk($sformatf("model_busy%0d", nr[i]),  {31'h0, b},   {31'h0, m_st[i] != 0});
        chk($sformatf("model_done%0d", nr[i]),  {31'h0, d},   {31'h0, m_st[i] == 2});
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        cmp(0, rk4, v4, i4, b4, d4);
        cmp(1, rk10, v10, i10, b10, d10);
    end

    task automatic wait_idle(input int max);
        int n;
        for (n = 0; n < max; n++) begin
            if (!b4 && !b10) break;
            @(negedge clk);
        end
        if (n == max) chk("timeout_idle", 32'd0, 32'd1);
    endtask

    task automatic load_pulse(input logic [31:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    logic [7:0] lit4  [4]  = '{8'h10, 8'h20, 8'h37, 8'h4C};
    logic [7:0] lit10 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    initial begin
        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        rk_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", {31'h0, v4}, 32'd0);
        chk("reset_rk",    {24'h0, rk4}, 32'd0);
        chk("reset_busy",  {31'h0, b10}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Four-round sequence with continuous ready.
        load_pulse(32'h11223344);
        for (int j = 0; j < 4; j++) begin
            chk("seq4_rk",  {24'h0, rk4}, {24'h0, lit4[j]});
            chk("seq4_idx", {28'h0, i4},  32'(j));
            @(negedge clk);
        end
        chk("seq4_done", {31'h0, d4}, 32'd1);
        @(negedge clk);
        chk("seq4_done_once", {31'h0, d4}, 32'd0);
        wait_idle(30);
        @(negedge clk);

        // Zero key: round keys are the bare constants, through the 0x1B reduction.
        load_pulse(32'h0);
        for (int j = 0; j < 10; j++) begin
            chk("seq10_rk", {24'h0, rk10}, {24'h0, lit10[j]});
            @(negedge clk);
        end
        chk("seq10_done", {31'h0, d10}, 32'd1);
        wait_idle(30);
        @(negedge clk);

        // Backpressure during index 1.
        load_pulse(32'h11223344);
        @(negedge clk);
        rk_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stall_rk",  {24'h0, rk4}, 32'h20);
            chk("stall_idx", {28'h0, i4},  32'd1);
            @(negedge clk);
        end
        rk_ready = 1'b1;
        chk("stall_hold_last", {24'h0, rk4}, 32'h20);
        @(negedge clk);
        chk("stall_resume", {24'h0, rk4}, 32'h37);
        wait_idle(30);
        @(negedge clk);

        // Load during GEN is ignored.
        load_pulse(32'h11223344);
        key_in   = 32'hFFFFFFFF;
        key_load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        key_load = 1'b0;
        chk("busy_load_ignored", {24'h0, rk4}, 32'h37);
        wait_idle(30);
        @(negedge clk);

        // Asynchronous reset mid round 2, then restart.
        load_pulse(32'h11223344);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_idx", {28'h0, i4}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_valid4", {31'h0, v4},  32'd0);
        chk("async_busy4",  {31'h0, b4},  32'd0);
        chk("async_busy10", {31'h0, b10}, 32'd0);
        chk("async_idx4",   {28'h0, i4},  32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        key_in   = 32'h0;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        chk("restart_rk",  {24'h0, rk10}, 32'h01);
        chk("restart_idx", {28'h0, i10},  32'd0);
        wait_idle(30);
        @(negedge clk);

        // key_load held across DONE: reload one cycle after returning to IDLE.
        key_in   = 32'h11223344;
        key_load = 1'b1;
        begin
            int n;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (d4) break;
            end
            if (n == 20) chk("timeout_done4", 32'd0, 32'd1);
        end
        key_in = 32'hAABBCCDD;
        @(negedge clk);
        chk("held_idle_busy", {31'h0, b4}, 32'd0);
        @(negedge clk);
        chk("held_reload_valid", {31'h0, v4}, 32'd1);
        chk("held_reload_rk", {24'h0, rk4}, 32'hAB);
        chk("held_reload_idx", {28'h0, i4}, 32'd0);
        key_load = 1'b0;
        wait_idle(40);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
